// File: rtl/uart_rx_byte.sv
// UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// Emits a one-cycle Flag_Rx with Rx_data for each clean frame and drops bad ones.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] Rx_data,
    output logic       Flag_Rx,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam logic [11:0] HALF_TC = 12'(CLKS_PER_BIT / 2 - 1);
    localparam logic [11:0] FULL_TC = 12'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        par_bad_q, par_bad_d;
    logic        flag_q, flag_d;
    logic        ferr_q, ferr_d;
    logic        perr_q, perr_d;
    logic        sync1_q, sync2_q, rxs_prev_q;
    logic        rxs;

    assign rxs = sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            par_bad_q  <= 1'b0;
            flag_q     <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            par_bad_q  <= par_bad_d;
            flag_q     <= flag_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            sync1_q    <= serial_in;
            sync2_q    <= sync1_q;
            rxs_prev_q <= rxs;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 12'd1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        par_bad_d = par_bad_q;
        flag_d    = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rxs_prev_q && !rxs) state_d = S_START;
            end
            S_START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (cnt_q == HALF_TC) begin
                    cnt_d     = '0;
                    par_bad_d = 1'b0;
                    idx_d     = '0;
                    state_d   = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d     = '0;
                    par_bad_d = (^shift_q) ^ rxs;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving at mid-stop lets the next start edge be caught with no gap.
                if (cnt_q == FULL_TC) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = S_IDLE;
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d = shift_q;
                            flag_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign Rx_data    = data_q;
    assign Flag_Rx    = flag_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: an 8N1 instance and an even-parity instance at 16 clocks/bit,
// a table of single frames plus hand-written back-to-back, glitch, break and reset sequences.
module tb_uart_rx_byte;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser0, ser1;
    logic [7:0] rx0, rx1;
    logic       flag0, flag1, busy0, busy1, ferr0, ferr1, perr0, perr1;

    always #5 clk = ~clk;

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .serial_in(ser0), .Rx_data(rx0), .Flag_Rx(flag0),
        .busy(busy0), .frame_err(ferr0), .parity_err(perr0)
    );

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .serial_in(ser1), .Rx_data(rx1), .Flag_Rx(flag1),
        .busy(busy1), .frame_err(ferr1), .parity_err(perr1)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int flag_cnt [2];
    int ferr_cnt [2];
    int perr_cnt [2];
    int excl_bad = 0;
    logic [7:0] got_q0 [$];
    int         flag_t0 [$];

    always @(posedge clk) cycle++;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (flag0) begin
                flag_cnt[0]++;
                got_q0.push_back(rx0);
                flag_t0.push_back(cycle);
            end
            if (ferr0) ferr_cnt[0]++;
            if (perr0) perr_cnt[0]++;
            if (flag1) flag_cnt[1]++;
            if (ferr1) ferr_cnt[1]++;
            if (perr1) perr_cnt[1]++;
            if ((int'(flag0) + int'(ferr0) + int'(perr0)) > 1) excl_bad++;
            if ((int'(flag1) + int'(ferr1) + int'(perr1)) > 1) excl_bad++;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive_bit(input int dev, input logic b);
        @(negedge clk);
        if (dev == 0) ser0 = b;
        else ser1 = b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic idle(input int dev, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dev == 0) ser0 = 1'b1;
            else ser1 = 1'b1;
        end
    endtask

    task automatic send_frame(input int dev, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        drive_bit(dev, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(dev, d[i]);
        if (has_par) drive_bit(dev, par);
        drive_bit(dev, stop);
    endtask

    typedef struct {
        int         dev;
        logic [7:0] data;
        logic       par;
        int         exp_flag;
        int         exp_ferr;
        int         exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int f0, e0, p0, n0;
        int fd, ed, pd;
        logic [7:0] rxv;
        logic [7:0] b99;

        ser0 = 1'b1;
        ser1 = 1'b1;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx0", rx0, 8'h00);
        check("rst_flag0", flag0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_errs0", {ferr0, perr0}, 0);
        check("rst_rx1", rx1, 8'h00);
        check("rst_busy1", busy1, 0);
        rst = 1'b0;
        idle(0, 10);

        // 0x07 has three ones, so even parity is 1; 0x00 and 0xFF take parity 0.
        vecs[0] = '{0, 8'hFE, 1'b0, 1, 0, 0, 8'hFE};
        vecs[1] = '{1, 8'h07, 1'b1, 1, 0, 0, 8'h07};
        vecs[2] = '{1, 8'h07, 1'b0, 0, 0, 1, 8'h07};
        vecs[3] = '{1, 8'h00, 1'b0, 1, 0, 0, 8'h00};
        vecs[4] = '{1, 8'hFF, 1'b0, 1, 0, 0, 8'hFF};

        for (int i = 0; i < 5; i++) begin
            fd = flag_cnt[vecs[i].dev];
            ed = ferr_cnt[vecs[i].dev];
            pd = perr_cnt[vecs[i].dev];
            send_frame(vecs[i].dev, vecs[i].data, vecs[i].dev == 1, vecs[i].par, 1'b1);
            idle(vecs[i].dev, 24);
            rxv = (vecs[i].dev == 0) ? rx0 : rx1;
            check($sformatf("v%0d_flag", i), flag_cnt[vecs[i].dev] - fd, vecs[i].exp_flag);
            check($sformatf("v%0d_ferr", i), ferr_cnt[vecs[i].dev] - ed, vecs[i].exp_ferr);
            check($sformatf("v%0d_perr", i), perr_cnt[vecs[i].dev] - pd, vecs[i].exp_perr);
            check($sformatf("v%0d_data", i), rxv, vecs[i].exp_data);
            check($sformatf("v%0d_busy", i), (vecs[i].dev == 0) ? busy0 : busy1, 0);
        end

        // Back-to-back frames with no idle gap: strobes exactly 10 bit times apart.
        n0 = flag_t0.size();
        send_frame(0, 8'hFE, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h18, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h04, 1'b0, 1'b0, 1'b1);
        idle(0, 24);
        check("b2b_count", flag_t0.size() - n0, 3);
        if (flag_t0.size() >= n0 + 3) begin
            check("b2b_d0", got_q0[n0], 8'hFE);
            check("b2b_d1", got_q0[n0 + 1], 8'h18);
            check("b2b_d2", got_q0[n0 + 2], 8'h04);
            check("b2b_gap01", flag_t0[n0 + 1] - flag_t0[n0], 10 * CPB);
            check("b2b_gap12", flag_t0[n0 + 2] - flag_t0[n0 + 1], 10 * CPB);
        end

        // Short low pulse: START must abort without any pulse.
        f0 = flag_cnt[0]; e0 = ferr_cnt[0]; p0 = perr_cnt[0];
        @(negedge clk); ser0 = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk); ser0 = 1'b1;
        idle(0, 30);
        check("glitch_busy", busy0, 0);
        check("glitch_pulses", (flag_cnt[0] - f0) + (ferr_cnt[0] - e0) + (perr_cnt[0] - p0), 0);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(0, 24);
        check("glitch_next_flag", flag_cnt[0] - f0, 1);
        check("glitch_next_data", rx0, 8'hA5);

        // Stop bit low followed by a held-low line: one frame_err, busy until release.
        f0 = flag_cnt[0]; e0 = ferr_cnt[0];
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("brk_busy_low", busy0, 1);
        check("brk_ferr", ferr_cnt[0] - e0, 1);
        check("brk_flag", flag_cnt[0] - f0, 0);
        check("brk_data_kept", rx0, 8'hA5);
        idle(0, 10);
        check("brk_busy_rel", busy0, 0);
        check("brk_ferr_once", ferr_cnt[0] - e0, 1);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle(0, 24);
        check("brk_next_flag", flag_cnt[0] - f0, 1);
        check("brk_next_data", rx0, 8'h3C);

        // Reset during bit 4 of 0x99; the line then goes idle.
        f0 = flag_cnt[0]; e0 = ferr_cnt[0]; p0 = perr_cnt[0];
        b99 = 8'h99;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, b99[i]);
        @(negedge clk); ser0 = b99[4];
        repeat (7) @(negedge clk);
        check("mid_busy_pre", busy0, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_data", rx0, 8'h00);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_flag", flag0, 0);
        rst = 1'b0;
        ser0 = 1'b1;
        idle(0, 12 * CPB);
        check("mid_no_pulse", (flag_cnt[0] - f0) + (ferr_cnt[0] - e0) + (perr_cnt[0] - p0), 0);
        check("mid_data_held", rx0, 8'h00);
        send_frame(0, 8'h66, 1'b0, 1'b0, 1'b1);
        idle(0, 24);
        check("mid_next_flag", flag_cnt[0] - f0, 1);
        check("mid_next_data", rx0, 8'h66);

        check("pulse_exclusive", excl_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial UART receiver, 8 data bits, LSB first, optional even parity, one stop bit.
- Sits directly upstream of the command/matrix parser.
- Converts the asynchronous serial line into a byte (Rx_data) plus a one-cycle strobe (Flag_Rx); the parser advances exactly once per strobe.
- Rejects start-bit glitches, bad stop bits and parity errors so that only clean bytes reach the parser.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal range 8..4095.
- PARITY_EN, 0, 1 = even parity bit expected between data and stop; 0 = 8N1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- serial_in  in  1  asynchronous UART line, idle high
- Rx_data  out  8  last correctly received byte
- Flag_Rx  out  1  one-cycle pulse: Rx_data updated with a new byte this cycle
- busy  out  1  high while a frame is in progress (states other than IDLE)
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- parity_err  out  1  one-cycle pulse: parity mismatch (PARITY_EN=1 only)

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=IDLE; bit counter=0; bit index=0; shift register=0.
  - Rx_data=8'h00; Flag_Rx=0; busy=0; frame_err=0; parity_err=0.
  - Both synchronizer flops preset to 1.
  - Reset mid-frame abandons the frame with no strobe or error pulse.
- Input path: two-flop synchronizer on serial_in, giving 2 cycles of latency; all decisions use the synchronized value `rxs`.
- Counter: 12-bit cycle counter, cleared on every state change.
- States:
  - IDLE: on a falling edge of rxs (previous 1, current 0) go to START. Otherwise stay.
  - START: count to CLKS_PER_BIT/2-1 (integer division). At terminal count:
    - rxs=0 → DATA, bit index=0.
    - rxs=1 → IDLE (glitch); no error pulse.
  - DATA: count to CLKS_PER_BIT-1. At terminal count:
    - shift rxs in at bit 7 (right shift), so bit 0 is received first.
    - Increment bit index; after the 8th bit go to PARITY if PARITY_EN, else STOP.
  - PARITY: count to CLKS_PER_BIT-1. At terminal count, latch the mismatch flag (XOR of 8 data bits XOR rxs ≠ 0), then go to STOP.
  - STOP: count to CLKS_PER_BIT-1. At terminal count:
    - rxs=1 and no parity mismatch → Rx_data ← shift register, Flag_Rx=1 for the next cycle only, go to IDLE.
    - rxs=1 with parity mismatch → parity_err pulse, Rx_data unchanged, no Flag_Rx, go to IDLE.
    - rxs=0 → frame_err pulse, Rx_data unchanged, no Flag_Rx, go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. A low line is never treated as a new start bit.
- Output timing:
  - Flag_Rx, frame_err and parity_err are registered, mutually exclusive, and at most one cycle wide per frame.
  - Rx_data is stable from the Flag_Rx cycle until the next successful frame.
- Back-to-back frames: the IDLE state is entered at the middle of the stop bit, so a start edge arriving half a bit later is detected. No gap is required between frames.
- busy = (state ≠ IDLE). busy is high in BREAK.

Test Plan:
- CLKS_PER_BIT=16, PARITY_EN=0. Send 0xFE (8N1) → exactly one Flag_Rx pulse; Rx_data=8'hFE; frame_err=0; parity_err=0; busy returns to 0.
- Back-to-back 0xFE, 0x18, 0x04 with no idle gap → three Flag_Rx pulses, each 160 cycles apart; Rx_data=FE, 18, 04 in order.
- Drive serial_in low for 5 cycles, then high → START aborts to IDLE; no Flag_Rx, no error pulse; a following 0xA5 is received correctly.
- Send 0x55 with stop bit forced 0, hold the line low for 40 cycles, then release → one frame_err pulse, no Flag_Rx, busy held high until the line goes high, Rx_data keeps its prior value; the next byte 0x3C is received correctly.
- PARITY_EN=1: send 0x07 with parity bit 1 → Flag_Rx, Rx_data=8'h07. Send 0x07 with parity bit 0 → parity_err pulse only.
- Assert rst for 1 cycle during bit 4 of 0x99 → all outputs are reset values and no pulse occurs; the next frame 0x66 yields Flag_Rx with Rx_data=8'h66.
